// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - multiplexed seven-segment display scanner with per-slot blanking
module seg_scan #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000,
  parameter int BLANK    = 500
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      wr_en_i,
  input  logic [$clog2(DIGITS)-1:0] wr_idx_i,
  input  logic [6:0]                wr_seg_i,
  input  logic [DIGITS-1:0]         dig_en_i,
  output logic [6:0]                seg_o,
  output logic [DIGITS-1:0]         an_o,
  output logic [$clog2(DIGITS)-1:0] digit_o,
  output logic                      frame_o
);

  localparam int IW = $clog2(DIGITS);
  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] DIG_LAST = IW'(DIGITS - 1);

  logic [6:0]    store [DIGITS];
  logic [CW-1:0] div_cnt;
  logic [IW-1:0] digit;
  logic [IW-1:0] digit_nxt;
  logic [6:0]    cur_pat;
  logic          slot_end;
  logic          blank_ph;
  logic          wr_ok;

  assign slot_end  = (div_cnt == DIV_LAST);
  assign digit_nxt = (digit == DIG_LAST) ? '0 : digit + 1'b1;
  // Index range check is done one bit wider so DIGITS itself is representable.
  assign wr_ok     = wr_en_i && ({1'b0, wr_idx_i} < (IW + 1)'(DIGITS));

  // With no blanking interval the slot is in SHOW phase from its first cycle.
  generate
    if (BLANK == 0) begin : g_no_blank
      assign blank_ph = 1'b0;
    end else begin : g_blank
      assign blank_ph = (div_cnt < CW'(BLANK));
    end
  endgenerate

  // Pattern store: CPU-side writes, out-of-range indices dropped.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DIGITS; i++) store[i] <= 7'h7F;
    end else if (wr_ok) begin
      store[wr_idx_i] <= wr_seg_i;
    end
  end

  // Slot timer, digit pointer and slot latch; the latch takes the pre-write store value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt <= '0;
      digit   <= '0;
      cur_pat <= 7'h7F;
    end else if (slot_end) begin
      div_cnt <= '0;
      digit   <= digit_nxt;
      cur_pat <= store[digit_nxt];
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Output phases: dark while blanking or in reset, else drive the latched pattern.
  always_comb begin
    seg_o = 7'h7F;
    an_o  = '1;
    if (rst_ni && !blank_ph) begin
      seg_o = cur_pat;
      if (dig_en_i[digit]) an_o = ~(DIGITS'(1) << digit);
    end
  end

  assign digit_o = digit;
  assign frame_o = slot_end && (digit == DIG_LAST);

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - self-checking bench for seg_scan with a frame-timing model
module tb_seg_scan;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 8;
  localparam int BLANK    = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_idx = '0;
  logic [6:0] wr_seg = '0;
  logic [3:0] dig_en = 4'hF;
  logic [6:0] seg;
  logic [3:0] an;
  logic [1:0] digit;
  logic       frame;

  int errors = 0;
  int checks = 0;
  logic chk_on = 1'b0;

  // model: edges since reset release, store contents, pattern captured at slot entry
  int         m_cyc;
  logic [6:0] m_store [DIGITS];
  logic [6:0] m_pat;

  seg_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK(BLANK)) dut (
    .clk_i(clk), .rst_ni(rst_n), .wr_en_i(wr_en), .wr_idx_i(wr_idx),
    .wr_seg_i(wr_seg), .dig_en_i(dig_en), .seg_o(seg), .an_o(an),
    .digit_o(digit), .frame_o(frame)
  );

  always #5 clk = ~clk;

  // model update: a new slot shows whatever the store held before this edge's write
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc = 0;
      m_pat = 7'h7F;
      for (int i = 0; i < DIGITS; i++) m_store[i] = 7'h7F;
    end else begin
      if (m_cyc % SCAN_DIV == SCAN_DIV - 1)
        m_pat = m_store[((m_cyc / SCAN_DIV) + 1) % DIGITS];
      if (wr_en) m_store[wr_idx] = wr_seg;
      m_cyc = m_cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, m_cyc);
    end
  endtask

  // every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      int ph, dg;
      logic [6:0] e_seg;
      logic [3:0] e_an;
      ph = m_cyc % SCAN_DIV;
      dg = (m_cyc / SCAN_DIV) % DIGITS;
      e_seg = 7'h7F;
      e_an  = 4'hF;
      if (rst_n && ph >= BLANK) begin
        e_seg = m_pat;
        if (dig_en[dg]) e_an = ~(4'b0001 << dg);
      end
      chk("model_seg", {9'd0, seg}, {9'd0, e_seg});
      chk("model_an", {12'd0, an}, {12'd0, e_an});
      chk("model_digit", {14'd0, digit}, 16'(rst_n ? dg : 0));
      chk("model_frame", {15'd0, frame},
          {15'd0, rst_n && ph == SCAN_DIV - 1 && dg == DIGITS - 1});
    end
  end

  task automatic run_to(input int n);
    int guard = 0;
    while (m_cyc < n && guard < 1000) begin
      @(posedge clk);
      #2;
      guard++;
    end
    if (m_cyc != n) begin
      errors++;
      checks++;
      $display("FAIL run_to: reached %0d expected %0d", m_cyc, n);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk_on = 1'b1;
    chk("reset_seg", {9'd0, seg}, 16'h007F);
    chk("reset_an", {12'd0, an}, 16'h000F);
    rst_n = 1'b1;

    // frame 0: all dark, frame pulse at cycle 31
    run_to(10);
    chk("f0_seg", {9'd0, seg}, 16'h007F);
    run_to(31);
    chk("frame31", {15'd0, frame}, 16'd1);
    run_to(32);
    chk("frame32", {15'd0, frame}, 16'd0);

    wr_en = 1'b1; wr_idx = 2'd1; wr_seg = 7'h79;
    run_to(33);
    wr_idx = 2'd2; wr_seg = 7'h24;
    run_to(34);
    wr_en = 1'b0;

    run_to(41);
    chk("d1_blank_an", {12'd0, an}, 16'h000F);
    chk("d1_blank_seg", {9'd0, seg}, 16'h007F);
    run_to(42);
    chk("d1_show_an", {12'd0, an}, 16'h000D);
    chk("d1_show_seg", {9'd0, seg}, 16'h0079);
    run_to(50);
    chk("d2_show_an", {12'd0, an}, 16'h000B);
    chk("d2_show_seg", {9'd0, seg}, 16'h0024);

    // digit 2 disabled for frame 2
    run_to(72);
    dig_en = 4'b1011;
    run_to(76);
    chk("en_d1_an", {12'd0, an}, 16'h000D);
    run_to(84);
    chk("en_d2_an", {12'd0, an}, 16'h000F);
    run_to(90);
    chk("en_d3_an", {12'd0, an}, 16'h0007);
    run_to(96);
    dig_en = 4'hF;

    // mid-slot write to the displayed digit
    run_to(108);
    wr_en = 1'b1; wr_idx = 2'd1; wr_seg = 7'h40;
    run_to(109);
    wr_en = 1'b0;
    run_to(110);
    chk("midslot_seg", {9'd0, seg}, 16'h0079);
    run_to(137);
    chk("next_blank_seg", {9'd0, seg}, 16'h007F);
    run_to(138);
    chk("next_show_seg", {9'd0, seg}, 16'h0040);

    // write on the slot-change edge
    run_to(143);
    wr_en = 1'b1; wr_idx = 2'd2; wr_seg = 7'h12;
    run_to(144);
    wr_en = 1'b0;
    run_to(146);
    chk("edge_old_seg", {9'd0, seg}, 16'h0024);
    run_to(178);
    chk("edge_new_seg", {9'd0, seg}, 16'h0012);

    // asynchronous reset mid-slot
    run_to(181);
    chk("pre_rst_an", {12'd0, an}, 16'h000B);
    rst_n = 1'b0;
    #1;
    chk("async_an", {12'd0, an}, 16'h000F);
    chk("async_seg", {9'd0, seg}, 16'h007F);
    chk("async_digit", {14'd0, digit}, 16'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    run_to(42);
    chk("post_rst_seg", {9'd0, seg}, 16'h007F);
    run_to(50);
    chk("post_rst_d2", {9'd0, seg}, 16'h007F);
    run_to(70);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg_scan.md
# seg_scan

Multiplexed seven-segment display scanner: the consumer end of the hex-to-segment decode path. It holds one active-low 7-bit segment pattern per digit, as produced by the hex digit decoder, and time-multiplexes them onto a shared cathode bus with one active-low anode per digit. Each digit slot starts with a blanking interval to suppress ghosting. It sits between the CPU-side display registers and the board's display pins.

## Interface
Parameters:
- DIGITS, 8: number of digits scanned (2..16).
- SCAN_DIV, 50000: clock cycles per digit slot (≥ 2).
- BLANK, 500: blanking cycles at the start of each slot. Must satisfy 0 ≤ BLANK < SCAN_DIV; 0 disables blanking.

Ports:
- clk_i  in  1  system clock; all state on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- wr_en_i  in  1  write strobe for the pattern store.
- wr_idx_i  in  $clog2(DIGITS)  digit index to write.
- wr_seg_i  in  7  segment pattern {g..a}, active-low (0 = lit).
- dig_en_i  in  DIGITS  per-digit enable; 0 keeps that digit dark.
- seg_o  out  7  shared cathodes, active-low.
- an_o  out  DIGITS  anodes, active-low, at most one low.
- digit_o  out  $clog2(DIGITS)  index of the current slot.
- frame_o  out  1  one-cycle pulse in the last cycle of a full scan.

## Operation
- Registers:
  - store[DIGITS] × 7: pattern store.
  - div_cnt: counts 0..SCAN_DIV-1.
  - digit: counts 0..DIGITS-1.
  - cur_pat: 7-bit slot latch.
- Reset (asynchronous, while rst_ni=0):
  - store all 7'h7F; cur_pat=7'h7F; div_cnt=0; digit=0.
  - Outputs: seg_o=7'h7F, an_o all ones, digit_o=0, frame_o=0.
- Write: if wr_en_i=1 and wr_idx_i<DIGITS, store[wr_idx_i] ← wr_seg_i on that edge. Out-of-range indices are ignored.
- Counter: div_cnt increments every cycle.
- Slot change: at the edge where div_cnt=SCAN_DIV-1:
  - div_cnt ← 0.
  - digit ← digit+1, wrapping DIGITS-1 → 0.
  - cur_pat ← store[new digit].
- Latch timing:
  - cur_pat is loaded only at slot entry. A write to the displayed digit during its slot has no visible effect until that digit's next slot.
  - A write on the same edge as the slot change is not seen by the entering slot, because the old store value is latched.
- Two output phases, combinational from registered state plus dig_en_i:
  - BLANK phase (div_cnt < BLANK): an_o all ones, seg_o=7'h7F.
  - SHOW phase (div_cnt ≥ BLANK): seg_o=cur_pat. an_o has only bit [digit] low if dig_en_i[digit]=1; otherwise an_o is all ones.
- dig_en_i changes act immediately and do not reset the counters.
- digit_o = digit.
- frame_o = 1 exactly when div_cnt=SCAN_DIV-1 and digit=DIGITS-1.

## Timing
- Slot length is SCAN_DIV cycles; a full frame is DIGITS×SCAN_DIV cycles.
- First slot after reset release: digit 0 with cur_pat=7'h7F, so it is dark. Stored patterns first appear from digit 1's slot onward; digit 0 first shows its pattern in the second frame.
- Write-to-store latency is 1 cycle. Write-to-display latency is up to one frame plus the blanking interval.
- frame_o period is DIGITS×SCAN_DIV cycles, width 1 cycle.
- Reset asserted mid-slot: outputs go dark immediately (asynchronous) and all storage is cleared.

## Test plan
Use DIGITS=4, SCAN_DIV=8, BLANK=2.
- Reset, release, run 32 cycles with dig_en_i=4'hF and no writes → an_o=4'hF in BLANK phases; seg_o=7'h7F at all times; frame_o high only at cycle 31.
- Write store[1]=7'h79 and store[2]=7'h24 before frame 2 → in digit-1 slot: div_cnt 0..1 gives an_o=4'hF, seg_o=7'h7F; div_cnt 2..7 gives an_o=4'b1101, seg_o=7'h79. Digit 2 shows an_o=4'b1011, seg_o=7'h24.
- dig_en_i=4'b1011 → during the digit-2 slot an_o=4'hF for all 8 cycles; other digits unaffected.
- Write store[1]=7'h40 at div_cnt=4 of digit 1's slot → seg_o stays 7'h79 for the rest of the slot; 7'h40 appears at div_cnt=2 of digit 1's next slot.
- Write store[2] on the edge with div_cnt=7, digit=1 → the digit-2 slot shows the old pattern; the new one shows next frame.
- Assert rst_ni low at div_cnt=5 of digit 2 → an_o=4'hF and seg_o=7'h7F without waiting for a clock edge; after release, digit_o=0 and all digits stay dark until rewritten.
